// File: rtl/stack_pkg.sv
// Shared definitions for the stack-calculator memory and its controller.
package stack_pkg;

  localparam int STACK_ADDR_W = 7;
  localparam int STACK_DATA_W = 8;
  localparam int STACK_DEPTH  = 128;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } seq_state_e;

endpackage : stack_pkg

// File: rtl/mem_clear_seq.sv
// Post-reset clear sequencer: walks every address once with a write strobe,
// then parks in RUN and raises ready until the next reset.
module mem_clear_seq
  import stack_pkg::*;
#(
  parameter int ADDR_W = STACK_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              ready,
  output logic              clr_we,
  output logic [ADDR_W-1:0] clr_addr
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

  seq_state_e        r_state;
  logic [ADDR_W-1:0] r_clr_ptr;
  logic              r_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= CLEAR;
      r_clr_ptr <= '0;
      r_ready   <= 1'b0;
    end else if (r_state == CLEAR) begin
      // The last address is written on the same edge that leaves CLEAR,
      // so the pointer never wraps back to zero.
      if (r_clr_ptr == LAST_ADDR) begin
        r_state <= RUN;
        r_ready <= 1'b1;
      end else begin
        r_clr_ptr <= r_clr_ptr + 1'b1;
      end
    end
  end

  assign clr_we   = (r_state == CLEAR);
  assign clr_addr = r_clr_ptr;
  assign ready    = r_ready;

endmodule : mem_clear_seq

// File: rtl/stack_memory.sv
// Single-port-write RAM for the stack calculator with a registered main read
// port, a registered debug read port and a post-reset clear sequence.
module stack_memory
  import stack_pkg::*;
#(
  parameter int                ADDR_W   = STACK_ADDR_W,
  parameter int                DATA_W   = STACK_DATA_W,
  parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_data,
  output logic              ready
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_rdata;
  logic [DATA_W-1:0] r_dbg_data;

  logic              w_run;
  logic              w_clr_we;
  logic [ADDR_W-1:0] w_clr_addr;
  logic              w_mem_we;
  logic [ADDR_W-1:0] w_mem_addr;
  logic [DATA_W-1:0] w_mem_wdata;
  logic              w_user_we;
  logic              w_dbg_fwd;

  mem_clear_seq #(
    .ADDR_W (ADDR_W)
  ) u_clear_seq (
    .clk      (clk),
    .rst_n    (rst_n),
    .ready    (w_run),
    .clr_we   (w_clr_we),
    .clr_addr (w_clr_addr)
  );

  // Controller writes are only honoured once the clear has finished; both
  // write sources share one port so the array maps onto a single RAM.
  assign w_user_we   = w_run & we;
  assign w_mem_we    = w_clr_we | w_user_we;
  assign w_mem_addr  = w_clr_we ? w_clr_addr : address;
  assign w_mem_wdata = w_clr_we ? INIT_VAL : wdata;
  assign w_dbg_fwd   = w_user_we && (dbg_addr == address);

  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      r_mem[w_mem_addr] <= w_mem_wdata;
    end
  end

  // Write-first on the main port, forwarding on the debug port when it
  // aliases the address being written.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rdata    <= '0;
      r_dbg_data <= '0;
    end else if (w_run) begin
      r_rdata    <= w_user_we ? wdata : r_mem[address];
      r_dbg_data <= w_dbg_fwd ? wdata : r_mem[dbg_addr];
    end else begin
      r_rdata    <= '0;
      r_dbg_data <= '0;
    end
  end

  assign rdata    = r_rdata;
  assign dbg_data = r_dbg_data;
  assign ready    = w_run;

endmodule : stack_memory

// File: tb/tb_stack_memory.sv
// Randomised bench for stack_memory against an array-based reference model.
module tb_stack_memory;

  localparam int AW    = 7;
  localparam int DW    = 8;
  localparam int DEPTH = 128;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          we;
  logic [AW-1:0] address;
  logic [DW-1:0] wdata;
  logic [DW-1:0] rdata;
  logic [AW-1:0] dbg_addr;
  logic [DW-1:0] dbg_data;
  logic          ready;

  int            n_checks = 0;
  int            n_errs   = 0;
  logic [DW-1:0] model [DEPTH];

  always #5 clk = ~clk;

  stack_memory #(
    .ADDR_W   (AW),
    .DATA_W   (DW),
    .INIT_VAL (8'h00)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .we       (we),
    .address  (address),
    .wdata    (wdata),
    .rdata    (rdata),
    .dbg_addr (dbg_addr),
    .dbg_data (dbg_data),
    .ready    (ready)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Assert reset, check the asynchronous clear of the outputs, then release
  // and expect ready exactly on the 128th edge with both read ports at zero.
  task automatic reset_and_clear();
    rst_n = 1'b0;
    #1;
    chk("rst_ready", {31'd0, ready}, 32'd0);
    chk("rst_rdata", {24'd0, rdata}, 32'd0);
    chk("rst_dbg", {24'd0, dbg_data}, 32'd0);
    step();
    step();
    rst_n = 1'b1;
    for (int i = 1; i <= DEPTH; i++) begin
      step();
      chk("clr_ready", {31'd0, ready}, (i == DEPTH) ? 32'd1 : 32'd0);
      chk("clr_rdata", {24'd0, rdata}, 32'd0);
      chk("clr_dbg", {24'd0, dbg_data}, 32'd0);
    end
    $display("txn clear complete at edge %0d", DEPTH);
    for (int a = 0; a < DEPTH; a++) model[a] = 8'h00;
  endtask

  task automatic drive_cycle(input logic w, input logic [AW-1:0] a,
                             input logic [DW-1:0] d, input logic [AW-1:0] da);
    logic [DW-1:0] exp_r;
    logic [DW-1:0] exp_d;
    we       = w;
    address  = a;
    wdata    = d;
    dbg_addr = da;
    exp_r = w ? d : model[a];
    exp_d = (w && (da == a)) ? d : model[da];
    if (w) model[a] = d;
    step();
    $display("txn we=%0d addr=%02h wdata=%02h dbg_addr=%02h -> rdata=%02h dbg_data=%02h",
             w, a, d, da, rdata, dbg_data);
    chk("rdata", {24'd0, rdata}, {24'd0, exp_r});
    chk("dbg_data", {24'd0, dbg_data}, {24'd0, exp_d});
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [AW-1:0] ra;
    logic [AW-1:0] rd;
    rst_n    = 1'b1;
    we       = 1'b1;
    address  = 7'd5;
    wdata    = 8'hAA;
    dbg_addr = 7'd0;
    #1;

    // Clear with a write held on the bus: it must be ignored.
    reset_and_clear();
    drive_cycle(1'b0, 7'd5, 8'h00, 7'd5);
    chk("addr5_after_clear", {24'd0, rdata}, 32'h00);

    drive_cycle(1'b1, 7'h7F, 8'h3C, 7'd0);
    drive_cycle(1'b0, 7'h7F, 8'h00, 7'd0);
    chk("rd_7f", {24'd0, rdata}, 32'h3C);

    drive_cycle(1'b1, 7'd10, 8'h55, 7'd10);
    chk("wr_first", {24'd0, rdata}, 32'h55);
    chk("dbg_fwd", {24'd0, dbg_data}, 32'h55);
    drive_cycle(1'b0, 7'd10, 8'h00, 7'd10);
    chk("rd_10", {24'd0, rdata}, 32'h55);

    drive_cycle(1'b1, 7'd0, 8'h11, 7'd0);
    drive_cycle(1'b1, 7'd1, 8'h22, 7'd0);
    drive_cycle(1'b0, 7'd0, 8'h00, 7'd1);
    chk("dual_main", {24'd0, rdata}, 32'h11);
    chk("dual_dbg", {24'd0, dbg_data}, 32'h22);

    // Random traffic; half the time confine addresses to force aliasing.
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 1) == 0) begin
        ra = AW'($urandom_range(0, 7));
        rd = AW'($urandom_range(0, 7));
      end else begin
        ra = AW'($urandom);
        rd = AW'($urandom);
      end
      drive_cycle(1'($urandom_range(0, 1)), ra, DW'($urandom), rd);
    end

    // Asynchronous reset mid-cycle while in RUN.
    drive_cycle(1'b1, 7'd20, 8'hF0, 7'd20);
    drive_cycle(1'b0, 7'd20, 8'h00, 7'd20);
    chk("rd_20", {24'd0, rdata}, 32'hF0);
    #3;
    reset_and_clear();
    drive_cycle(1'b0, 7'd20, 8'h00, 7'd20);
    chk("rd_20_cleared", {24'd0, rdata}, 32'h00);

    // Fill with nonzero data, then abort a clear halfway through.
    for (int a = 0; a < DEPTH; a++) begin
      drive_cycle(1'b1, AW'(a), DW'($urandom_range(1, 255)), AW'(a));
    end
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    repeat (64) step();
    chk("half_clr_ready", {31'd0, ready}, 32'd0);
    #3;
    reset_and_clear();
    for (int a = 0; a < DEPTH; a++) begin
      drive_cycle(1'b0, AW'(a), 8'h00, AW'(DEPTH - 1 - a));
      chk("reclr_main", {24'd0, rdata}, 32'h00);
    end

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule : tb_stack_memory
